pcie_tlp_master: RTL and testbench
==================================

// Module: pcie_tlp_master
// PURPOSE
//  Single-outstanding PCIe bus-master (requester) on the 16-bit-per-cycle x1 transaction-layer interface, VC0.
//  Turns user commands into 1-DW MWr32/MRd32 TLPs on the tx_*_vc0 port and matches the returning CplD/Cpl on rx_*_vc0.
//  Returns read data or status to the user; sits beside the existing target logic in the top level.
// PARAMETERS
//  TIMEOUT_CYCLES  50000  clk_125 cycles from MRd tx_end to give up on a completion (400 us)
//  TC              3'd0   traffic class placed in every request header
// PORTS
//  clk_125      in   1   transaction-layer clock, 125 MHz; sole clock
//  rst          in   1   asynchronous, active-high reset
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   block idle; command accepted when cmd_valid&cmd_ready
//  cmd_write    in   1   1=MWr, 0=MRd
//  cmd_addr     in   30  DW address [31:2]
//  cmd_be       in   4   first DW byte enables; last BE always 4'b0000
//  cmd_wdata    in   32  write data, big-endian byte order on the link
//  resp_valid   out  1   one-cycle response pulse
//  resp_rdata   out  32  read data (32'hFFFFFFFF on error/timeout/write)
//  resp_status  out  3   completion status (000 SC, 001 UR, 100 CA); 000 for writes
//  resp_timeout out  1   qualifies resp_valid: read timed out
//  bus_num/dev_num/func_num  in  8/5/3  requester ID from config space
//  tx_ca_ph     in   9   posted header credits
//  tx_ca_pd     in   13  posted data credits
//  tx_ca_nph    in   9   non-posted header credits
//  tx_req       out  1   request TX slot
//  tx_rdy       in   1   slot granted
//  tx_st/tx_end out  1   first/last halfword strobes
//  tx_data      out  16  TLP halfword
//  rx_st/rx_end in   1   received TLP first/last halfword
//  rx_data      in   16  received halfword
// BEHAVIOUR
//  Reset: cmd_ready=0 until first clk after rst low; tx_req/tx_st/tx_end/resp_valid/resp_timeout=0, tx_data=0,
//   resp_rdata=FFFFFFFF, resp_status=0, tag=0, FSM=IDLE. rst mid-TLP truncates it; outstanding read dropped, no resp.
//  FSM: IDLE -> CREDIT -> REQ -> SEND -> (write) RESP | (read) WAIT_CPL -> RESP -> IDLE.
//  IDLE: cmd_ready=1; on accept latch all cmd_* fields, cmd_ready=0 next cycle.
//  CREDIT: MWr needs tx_ca_ph!=0 && tx_ca_pd!=0; MRd needs tx_ca_nph!=0; stay until met.
//  REQ: tx_req=1 held until tx_rdy sampled 1; tx_req drops the next cycle.
//  SEND: first halfword on the cycle after tx_rdy sampled, one halfword per clk, no gaps; tx_st on H0, tx_end on last.
//   H0 {0,fmt,type=00000,0,TC,0000}, fmt=10 MWr / 00 MRd.  H1 {td0,ep0,attr00,00,len=10'd1}.
//   H2 {bus,dev,func}.  H3 {tag,4'b0000,cmd_be}.  H4 addr[31:16].  H5 {addr[15:2],00}.
//   MWr adds D0 wdata[31:16], D1 wdata[15:0]: 8 halfwords. MRd: 6 halfwords.
//  Write: resp_valid one cycle after tx_end, status 000, resp_timeout 0.
//  Read: tag increments (8-bit, wraps FF->00) after tx_end; WAIT_CPL starts timeout counter.
//  RX parser, active only in WAIT_CPL, restarts on each rx_st: H0 type[4:1]=0101 (Cpl/CplD), fmt[1]=1 means data present.
//   H3[15:13] status; H4 requester ID; H5[15:8] tag. Match = ID=={bus,dev,func} && tag==outstanding tag.
//   Non-matching or non-completion TLPs ignored to rx_end; never consume the response.
//  Matched, status 000 with data: resp_rdata={D0,D1}; else rdata FFFFFFFF, resp_status from H3.
//   resp_valid one cycle after the matching rx_end.
//  Timeout: counter reaches TIMEOUT_CYCLES with no match -> resp_valid=1, resp_timeout=1, rdata FFFFFFFF.
//   Match and timeout on same cycle: the match wins.
//  cmd_valid is ignored while busy; a command is never lost once accepted.
// TESTING
//  1 MWr addr 0x0000_1004, be F, data 0xDEADBEEF, credits ok, tx_rdy after 3 clk -> tx_data 4000,0001,ID,0x000F,0000,1004,DEAD,BEEF; tx_st on 1st, tx_end on 8th; resp_valid next clk.
//  2 MRd addr 0x0000_2000, be 1, ID 01:00.0 -> tx_data 0000,0001,0100,0x0001,0000,2000; inject CplD tag 00 data 0x12345678 -> resp_rdata 12345678, status 000.
//  3 Read, inject CplD with wrong tag 05, then correct tag 00 -> first ignored, single resp with the second's data.
//  4 Read with TIMEOUT_CYCLES=100, no completion -> resp_timeout=1 exactly 100 clk after tx_end, rdata FFFFFFFF; then Cpl status UR -> status 001.
//  5 tx_ca_nph=0 for 20 clk then 1 -> tx_req stays 0 until credit appears; 256 reads -> tag wraps FF->00.
//  6 rst asserted during SEND halfword 3 -> all outputs at reset values next edge; no resp_valid; new command then runs cleanly.

Source files
------------

// File: rtl/pcie_tlp_master_if.sv
// Command, response, transmit and receive signals of the PCIe requester.
// The master modport is the requester block itself; slave is the user/link side.
interface pcie_tlp_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [29:0] cmd_addr;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [2:0]  resp_status;
  logic        resp_timeout;

  logic [7:0]  bus_num;
  logic [4:0]  dev_num;
  logic [2:0]  func_num;

  logic [8:0]  tx_ca_ph;
  logic [12:0] tx_ca_pd;
  logic [8:0]  tx_ca_nph;

  logic        tx_req;
  logic        tx_rdy;
  logic        tx_st;
  logic        tx_end;
  logic [15:0] tx_data;

  logic        rx_st;
  logic        rx_end;
  logic [15:0] rx_data;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_wdata,
    output cmd_ready,
    output resp_valid, resp_rdata, resp_status, resp_timeout,
    input  bus_num, dev_num, func_num,
    input  tx_ca_ph, tx_ca_pd, tx_ca_nph,
    output tx_req, tx_st, tx_end, tx_data,
    input  tx_rdy,
    input  rx_st, rx_end, rx_data
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_wdata,
    input  cmd_ready,
    input  resp_valid, resp_rdata, resp_status, resp_timeout,
    output bus_num, dev_num, func_num,
    output tx_ca_ph, tx_ca_pd, tx_ca_nph,
    input  tx_req, tx_st, tx_end, tx_data,
    output tx_rdy,
    output rx_st, rx_end, rx_data
  );
endinterface

// File: rtl/pcie_tlp_master.sv
// Single-outstanding PCIe requester: builds 1-DW MWr32/MRd32 TLPs on the
// 16-bit VC0 transmit port and matches the returning Cpl/CplD on receive.
module pcie_tlp_master #(
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [2:0] TC             = 3'd0
) (
  input  logic              clk_125,
  input  logic              rst,
  pcie_tlp_master_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CREDIT, ST_REQ, ST_SEND, ST_WAIT_CPL, ST_RESP
  } state_t;

  state_t state_reg, state_next;

  logic          cmd_ready_reg;
  logic          write_reg;
  logic [29:0]   addr_reg;
  logic [3:0]    be_reg;
  logic [31:0]   wdata_reg;
  logic [7:0]    tag_reg;
  logic [7:0]    out_tag_reg;
  logic [2:0]    hw_cnt_reg;
  logic [TW-1:0] timer_reg;
  logic [31:0]   resp_rdata_reg;
  logic [2:0]    resp_status_reg;
  logic          resp_timeout_reg;

  logic          rx_active_reg;
  logic [2:0]    rx_idx_reg;
  logic          rx_is_cpl_reg, rx_is_cpl_next;
  logic          rx_has_data_reg, rx_has_data_next;
  logic [2:0]    rx_status_reg, rx_status_next;
  logic [15:0]   rx_id_reg, rx_id_next;
  logic [7:0]    rx_tag_reg, rx_tag_next;
  logic [15:0]   rx_d0_reg, rx_d0_next;

  logic          accept, credit_ok, send_last, timeout_hit;
  logic          rx_hw_valid, cpl_match, cpl_data_ok;
  logic [2:0]    hw_last, rx_cur_idx;
  logic [7:0]    rx_hit;
  logic [15:0]   req_id;
  logic [15:0]   tx_hw [8];
  logic          tx_req, tx_st, tx_end, resp_valid;
  logic [15:0]   tx_data;

  assign req_id    = {bus.bus_num, bus.dev_num, bus.func_num};
  assign accept    = bus.cmd_valid & cmd_ready_reg;
  assign credit_ok = write_reg ? ((bus.tx_ca_ph != 9'd0) && (bus.tx_ca_pd != 13'd0))
                               : (bus.tx_ca_nph != 9'd0);
  assign hw_last   = write_reg ? 3'd7 : 3'd5;
  assign send_last = (state_reg == ST_SEND) && (hw_cnt_reg == hw_last);
  // timer_reg counts cycles since tx_end; leaving here lands the pulse exactly TIMEOUT_CYCLES later
  assign timeout_hit = (state_reg == ST_WAIT_CPL) && (timer_reg == TW'(TIMEOUT_CYCLES - 1));

  // Request TLP halfwords in link order
  always_comb begin
    tx_hw[0] = {1'b0, (write_reg ? 2'b10 : 2'b00), 5'b00000, 1'b0, TC, 4'b0000};
    tx_hw[1] = {1'b0, 1'b0, 2'b00, 2'b00, 10'd1};
    tx_hw[2] = req_id;
    tx_hw[3] = {tag_reg, 4'b0000, be_reg};
    tx_hw[4] = addr_reg[29:14];
    tx_hw[5] = {addr_reg[13:0], 2'b00};
    tx_hw[6] = wdata_reg[31:16];
    tx_hw[7] = wdata_reg[15:0];
  end

  // Receive parser: a TLP is consumed halfword by halfword from rx_st through rx_end
  assign rx_hw_valid = (state_reg == ST_WAIT_CPL) && (bus.rx_st || rx_active_reg);
  assign rx_cur_idx  = bus.rx_st ? 3'd0 : rx_idx_reg;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rx_hit
      assign rx_hit[gi] = rx_hw_valid && (rx_cur_idx == 3'(gi));
    end
  endgenerate

  // Header fields including the halfword on the bus now, so rx_end can be judged in its own cycle
  always_comb begin
    rx_is_cpl_next   = rx_is_cpl_reg;
    rx_has_data_next = rx_has_data_reg;
    rx_status_next   = rx_status_reg;
    rx_id_next       = rx_id_reg;
    rx_tag_next      = rx_tag_reg;
    rx_d0_next       = rx_d0_reg;
    if (rx_hit[0]) begin
      rx_is_cpl_next   = (bus.rx_data[12:9] == 4'b0101);
      rx_has_data_next = bus.rx_data[14];
    end
    if (rx_hit[3]) rx_status_next = bus.rx_data[15:13];
    if (rx_hit[4]) rx_id_next     = bus.rx_data;
    if (rx_hit[5]) rx_tag_next    = bus.rx_data[15:8];
    if (rx_hit[6]) rx_d0_next     = bus.rx_data;
  end

  // A short TLP ending before H5 cannot match, so stale fields from an earlier TLP are harmless
  assign cpl_match = rx_hw_valid && bus.rx_end && rx_is_cpl_next && (rx_cur_idx >= 3'd5) &&
                     (rx_id_next == req_id) && (rx_tag_next == out_tag_reg);
  assign cpl_data_ok = rx_has_data_next && (rx_status_next == 3'b000) && (rx_cur_idx == 3'd7);

  // State register
  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and link/response strobes
  always_comb begin
    state_next = state_reg;
    tx_req     = 1'b0;
    tx_st      = 1'b0;
    tx_end     = 1'b0;
    tx_data    = 16'h0000;
    resp_valid = 1'b0;
    case (state_reg)
      ST_IDLE:     if (accept) state_next = ST_CREDIT;
      ST_CREDIT:   if (credit_ok) state_next = ST_REQ;
      ST_REQ: begin
        tx_req = 1'b1;
        if (bus.tx_rdy) state_next = ST_SEND;
      end
      ST_SEND: begin
        tx_data = tx_hw[hw_cnt_reg];
        tx_st   = (hw_cnt_reg == 3'd0);
        tx_end  = send_last;
        if (send_last) state_next = write_reg ? ST_RESP : ST_WAIT_CPL;
      end
      ST_WAIT_CPL: if (cpl_match || timeout_hit) state_next = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        state_next = ST_IDLE;
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  // Command latch, halfword counter, tag, timeout counter and response fields
  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      cmd_ready_reg    <= 1'b0;
      write_reg        <= 1'b0;
      addr_reg         <= '0;
      be_reg           <= '0;
      wdata_reg        <= '0;
      tag_reg          <= '0;
      out_tag_reg      <= '0;
      hw_cnt_reg       <= '0;
      timer_reg        <= '0;
      resp_rdata_reg   <= 32'hFFFF_FFFF;
      resp_status_reg  <= 3'b000;
      resp_timeout_reg <= 1'b0;
    end else begin
      cmd_ready_reg <= (state_next == ST_IDLE);
      if (accept) begin
        write_reg <= bus.cmd_write;
        addr_reg  <= bus.cmd_addr;
        be_reg    <= bus.cmd_be;
        wdata_reg <= bus.cmd_wdata;
      end
      if (state_reg == ST_SEND) begin
        hw_cnt_reg <= send_last ? 3'd0 : hw_cnt_reg + 3'd1;
        if (send_last) begin
          if (write_reg) begin
            resp_rdata_reg   <= 32'hFFFF_FFFF;
            resp_status_reg  <= 3'b000;
            resp_timeout_reg <= 1'b0;
          end else begin
            out_tag_reg <= tag_reg;
            tag_reg     <= tag_reg + 8'd1;
            timer_reg   <= TW'(1);
          end
        end
      end
      if (state_reg == ST_WAIT_CPL) begin
        timer_reg <= timer_reg + TW'(1);
        if (cpl_match) begin
          resp_rdata_reg   <= cpl_data_ok ? {rx_d0_next, bus.rx_data} : 32'hFFFF_FFFF;
          resp_status_reg  <= rx_status_next;
          resp_timeout_reg <= 1'b0;
        end else if (timeout_hit) begin
          resp_rdata_reg   <= 32'hFFFF_FFFF;
          resp_status_reg  <= 3'b000;
          resp_timeout_reg <= 1'b1;
        end
      end
    end
  end

  // Receive parser state; cleared whenever no read is outstanding
  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      rx_active_reg   <= 1'b0;
      rx_idx_reg      <= '0;
      rx_is_cpl_reg   <= 1'b0;
      rx_has_data_reg <= 1'b0;
      rx_status_reg   <= '0;
      rx_id_reg       <= '0;
      rx_tag_reg      <= '0;
      rx_d0_reg       <= '0;
    end else if (state_reg != ST_WAIT_CPL) begin
      rx_active_reg <= 1'b0;
      rx_idx_reg    <= '0;
    end else if (rx_hw_valid) begin
      rx_active_reg   <= !bus.rx_end;
      rx_idx_reg      <= (rx_cur_idx == 3'd7) ? 3'd7 : rx_cur_idx + 3'd1;
      rx_is_cpl_reg   <= rx_is_cpl_next;
      rx_has_data_reg <= rx_has_data_next;
      rx_status_reg   <= rx_status_next;
      rx_id_reg       <= rx_id_next;
      rx_tag_reg      <= rx_tag_next;
      rx_d0_reg       <= rx_d0_next;
    end
  end

  assign bus.cmd_ready    = cmd_ready_reg;
  assign bus.tx_req       = tx_req;
  assign bus.tx_st        = tx_st;
  assign bus.tx_end       = tx_end;
  assign bus.tx_data      = tx_data;
  assign bus.resp_valid   = resp_valid;
  assign bus.resp_rdata   = resp_rdata_reg;
  assign bus.resp_status  = resp_status_reg;
  assign bus.resp_timeout = resp_timeout_reg;

endmodule

// File: tb/tb_pcie_tlp_master.sv
// Bench for pcie_tlp_master: scoreboard queues for transmitted halfwords and responses.
module tb_pcie_tlp_master;

  localparam int          TO = 100;
  localparam logic [15:0] ID = 16'h0100;

  logic clk_125 = 1'b0;
  logic rst     = 1'b1;
  always #4 clk_125 = ~clk_125;

  pcie_tlp_master_if b ();
  pcie_tlp_master #(.TIMEOUT_CYCLES(TO), .TC(3'd0)) dut (.clk_125(clk_125), .rst(rst), .bus(b));

  typedef struct { logic [15:0] data; logic st; logic en; } tx_exp_t;
  typedef struct { logic [31:0] rdata; logic [2:0] status; logic tmo; } resp_exp_t;

  tx_exp_t   tx_q[$];
  resp_exp_t resp_q[$];
  tx_exp_t   txm_e;
  resp_exp_t rsm_e;

  int total = 0, bad = 0;
  int cyc = 0;
  int last_tx_end_cyc = 0, last_resp_cyc = 0, rx_end_cyc = 0;
  int resp_cnt = 0, tlp_cnt = 0;
  bit in_tlp = 0;
  logic [7:0] tag_model = 8'h00;

  always @(posedge clk_125) cyc <= cyc + 1;

  // Transmit monitor: every halfword of a TLP is checked against the queue
  always @(negedge clk_125) begin
    if (rst) begin
      in_tlp = 0;
    end else if (in_tlp || b.tx_st === 1'b1) begin
      total++;
      if (tx_q.size() == 0) begin
        bad++;
        $display("FAIL tx_extra: got data=%h st=%b end=%b, required no halfword", b.tx_data, b.tx_st, b.tx_end);
      end else begin
        txm_e = tx_q.pop_front();
        if (b.tx_data !== txm_e.data || b.tx_st !== txm_e.st || b.tx_end !== txm_e.en) begin
          bad++;
          $display("FAIL tx_halfword: got data=%h st=%b end=%b, required data=%h st=%b end=%b",
                   b.tx_data, b.tx_st, b.tx_end, txm_e.data, txm_e.st, txm_e.en);
        end
      end
      in_tlp = (b.tx_end !== 1'b1);
      if (b.tx_end === 1'b1) begin
        last_tx_end_cyc = cyc;
        tlp_cnt++;
        $display("tx tlp %0d complete at cycle %0d", tlp_cnt, cyc);
      end
    end
  end

  // Response monitor
  always @(negedge clk_125) begin
    if (!rst && b.resp_valid === 1'b1) begin
      last_resp_cyc = cyc;
      resp_cnt++;
      total++;
      $display("resp %0d: rdata=%h status=%0d timeout=%0b cycle=%0d", resp_cnt, b.resp_rdata, b.resp_status, b.resp_timeout, cyc);
      if (resp_q.size() == 0) begin
        bad++;
        $display("FAIL resp_extra: got rdata=%h, required no response", b.resp_rdata);
      end else begin
        rsm_e = resp_q.pop_front();
        if (b.resp_rdata !== rsm_e.rdata || b.resp_status !== rsm_e.status || b.resp_timeout !== rsm_e.tmo) begin
          bad++;
          $display("FAIL resp_fields: got rdata=%h status=%0d tmo=%b, required rdata=%h status=%0d tmo=%b",
                   b.resp_rdata, b.resp_status, b.resp_timeout, rsm_e.rdata, rsm_e.status, rsm_e.tmo);
        end
      end
    end
  end

  initial begin
    #640000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_req(input bit wr, input logic [29:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input logic [7:0] tag);
    logic [15:0] h[8];
    int n;
    h[0] = wr ? 16'h4000 : 16'h0000;
    h[1] = 16'h0001;
    h[2] = ID;
    h[3] = {tag, 4'b0000, be};
    h[4] = addr[29:14];
    h[5] = {addr[13:0], 2'b00};
    h[6] = wd[31:16];
    h[7] = wd[15:0];
    n = wr ? 8 : 6;
    for (int i = 0; i < n; i++) tx_q.push_back('{data: h[i], st: (i == 0), en: (i == n - 1)});
  endtask

  task automatic issue_cmd(input bit wr, input logic [29:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, output logic [7:0] tag);
    int n = 0;
    tag = tag_model;
    while (n < 200) begin
      @(posedge clk_125); #1;
      if (b.cmd_ready === 1'b1) break;
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL cmd_ready_wait: got cmd_ready=%b for 200 cycles, required 1", b.cmd_ready);
      return;
    end
    b.cmd_write = wr; b.cmd_addr = addr; b.cmd_be = be; b.cmd_wdata = wd; b.cmd_valid = 1'b1;
    push_req(wr, addr, be, wd, tag_model);
    if (!wr) tag_model = tag_model + 8'd1;
    @(posedge clk_125); #1;
    b.cmd_valid = 1'b0;
  endtask

  task automatic grant(input int dly);
    int n = 0;
    while (n < 200 && b.tx_req !== 1'b1) begin
      @(posedge clk_125); #1; n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL tx_req_wait: got tx_req=%b for 200 cycles, required 1", b.tx_req);
      return;
    end
    repeat (dly) begin @(posedge clk_125); #1; end
    b.tx_rdy = 1'b1;
    @(posedge clk_125); #1;
    b.tx_rdy = 1'b0;
    total++;
    if (b.tx_req !== 1'b0) begin
      bad++;
      $display("FAIL tx_req_drop: got tx_req=%b after grant, required 0", b.tx_req);
    end
  endtask

  task automatic wait_tlp(input int start);
    int n = 0;
    while (n < 50 && tlp_cnt == start) begin @(posedge clk_125); #1; n++; end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL tlp_wait: got %0d tlps, required %0d", tlp_cnt, start + 1);
    end
  endtask

  task automatic wait_resp(input int start, input int budget);
    int n = 0;
    while (n < budget && resp_cnt == start) begin @(posedge clk_125); #1; n++; end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL resp_wait: got %0d responses, required %0d", resp_cnt, start + 1);
    end
  endtask

  task automatic send_cpl(input logic [7:0] tag, input logic [15:0] rid, input logic [2:0] st,
                          input bit data, input logic [31:0] d, input bit is_cpl);
    logic [15:0] h[8];
    int n;
    h[0] = is_cpl ? (data ? 16'h4A00 : 16'h0A00) : 16'h4000;
    h[1] = 16'h0001;
    h[2] = 16'h0000;
    h[3] = {st, 1'b0, 12'd4};
    h[4] = rid;
    h[5] = {tag, 8'h00};
    h[6] = d[31:16];
    h[7] = d[15:0];
    n = data ? 8 : 6;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_125); #1;
      b.rx_st = (i == 0); b.rx_end = (i == n - 1); b.rx_data = h[i];
      if (i == n - 1) rx_end_cyc = cyc;
    end
    @(posedge clk_125); #1;
    b.rx_st = 1'b0; b.rx_end = 1'b0; b.rx_data = 16'h0000;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_125); #1;
    total++;
    if ({b.cmd_ready, b.tx_req, b.tx_st, b.tx_end, b.resp_valid, b.resp_timeout} !== 6'b0) begin
      bad++;
      $display("FAIL reset_strobes: got ready/req/st/end/rv/tmo=%b, required 000000",
               {b.cmd_ready, b.tx_req, b.tx_st, b.tx_end, b.resp_valid, b.resp_timeout});
    end
    total++;
    if (b.tx_data !== 16'h0000 || b.resp_rdata !== 32'hFFFF_FFFF || b.resp_status !== 3'd0) begin
      bad++;
      $display("FAIL reset_data: got tx_data=%h rdata=%h status=%0d, required 0000 ffffffff 0",
               b.tx_data, b.resp_rdata, b.resp_status);
    end
    rst = 1'b0;
    #1;
    total++;
    if (b.cmd_ready !== 1'b0) begin
      bad++; $display("FAIL ready_after_release: got %b, required 0", b.cmd_ready);
    end
    @(posedge clk_125); #1;
    total++;
    if (b.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL ready_first_clk: got %b, required 1", b.cmd_ready);
    end
  endtask

  task automatic test_write();
    logic [7:0] t;
    int r0 = resp_cnt;
    resp_q.push_back('{rdata: 32'hFFFF_FFFF, status: 3'd0, tmo: 1'b0});
    issue_cmd(1'b1, 30'h0000_0401, 4'hF, 32'hDEAD_BEEF, t);
    total++;
    if (b.cmd_ready !== 1'b0) begin
      bad++; $display("FAIL ready_after_accept: got %b, required 0", b.cmd_ready);
    end
    grant(3);
    wait_resp(r0, 40);
    total++;
    if (last_resp_cyc !== last_tx_end_cyc + 1) begin
      bad++; $display("FAIL write_resp_latency: got %0d cycles, required 1", last_resp_cyc - last_tx_end_cyc);
    end
  endtask

  task automatic test_read();
    logic [7:0] t;
    int r0 = resp_cnt;
    int t0 = tlp_cnt;
    bit seen_ready = 0;
    issue_cmd(1'b0, 30'h0000_0800, 4'h1, 32'h0, t);
    grant(1);
    wait_tlp(t0);
    // commands offered while busy must be ignored
    b.cmd_valid = 1'b1; b.cmd_write = 1'b1;
    repeat (5) begin
      @(posedge clk_125); #1;
      if (b.cmd_ready !== 1'b0) seen_ready = 1;
    end
    b.cmd_valid = 1'b0;
    total++;
    if (seen_ready) begin
      bad++; $display("FAIL busy_ready: got cmd_ready=1 while busy, required 0");
    end
    resp_q.push_back('{rdata: 32'h1234_5678, status: 3'd0, tmo: 1'b0});
    send_cpl(t, ID, 3'd0, 1'b1, 32'h1234_5678, 1'b1);
    wait_resp(r0, 20);
    total++;
    if (last_resp_cyc !== rx_end_cyc + 1) begin
      bad++; $display("FAIL read_resp_latency: got %0d cycles, required 1", last_resp_cyc - rx_end_cyc);
    end
  endtask

  task automatic test_wrong_tag();
    logic [7:0] t;
    int r0 = resp_cnt;
    int t0 = tlp_cnt;
    issue_cmd(1'b0, 30'h0123_4567, 4'hC, 32'h0, t);
    grant(2);
    wait_tlp(t0);
    send_cpl(t ^ 8'h05, ID, 3'd0, 1'b1, 32'hBAD0_0001, 1'b1);
    send_cpl(t, ID, 3'd0, 1'b1, 32'hBAD0_0002, 1'b0);
    send_cpl(t, 16'h0200, 3'd0, 1'b1, 32'hBAD0_0003, 1'b1);
    repeat (3) @(posedge clk_125); #1;
    total++;
    if (resp_cnt !== r0) begin
      bad++; $display("FAIL ignore_nonmatch: got %0d responses, required %0d", resp_cnt, r0);
    end
    resp_q.push_back('{rdata: 32'hCAFE_F00D, status: 3'd0, tmo: 1'b0});
    send_cpl(t, ID, 3'd0, 1'b1, 32'hCAFE_F00D, 1'b1);
    wait_resp(r0, 20);
    repeat (5) @(posedge clk_125); #1;
    total++;
    if (resp_cnt !== r0 + 1) begin
      bad++; $display("FAIL single_resp: got %0d responses, required %0d", resp_cnt - r0, 1);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] t, t_old;
    int r0 = resp_cnt;
    int t0 = tlp_cnt;
    issue_cmd(1'b0, 30'h0000_0010, 4'hF, 32'h0, t_old);
    grant(0);
    wait_tlp(t0);
    resp_q.push_back('{rdata: 32'hFFFF_FFFF, status: 3'd0, tmo: 1'b1});
    wait_resp(r0, 300);
    total++;
    if (last_resp_cyc - last_tx_end_cyc !== TO) begin
      bad++; $display("FAIL timeout_latency: got %0d cycles, required %0d", last_resp_cyc - last_tx_end_cyc, TO);
    end
    r0 = resp_cnt;
    t0 = tlp_cnt;
    issue_cmd(1'b0, 30'h0000_0020, 4'hF, 32'h0, t);
    grant(0);
    wait_tlp(t0);
    send_cpl(t_old, ID, 3'd0, 1'b1, 32'h0BAD_0BAD, 1'b1);
    resp_q.push_back('{rdata: 32'hFFFF_FFFF, status: 3'd1, tmo: 1'b0});
    send_cpl(t, ID, 3'd1, 1'b0, 32'h0, 1'b1);
    wait_resp(r0, 20);
  endtask

  task automatic test_credit_wait();
    logic [7:0] t;
    int r0 = resp_cnt;
    int t0 = tlp_cnt;
    bit saw_req = 0;
    b.tx_ca_nph = 9'd0;
    issue_cmd(1'b0, 30'h0000_0100, 4'h3, 32'h0, t);
    repeat (20) begin
      @(posedge clk_125); #1;
      if (b.tx_req !== 1'b0) saw_req = 1;
    end
    total++;
    if (saw_req) begin
      bad++; $display("FAIL credit_block: got tx_req=1 with no nph credit, required 0");
    end
    b.tx_ca_nph = 9'd1;
    grant(0);
    wait_tlp(t0);
    resp_q.push_back('{rdata: 32'hA5A5_5A5A, status: 3'd0, tmo: 1'b0});
    send_cpl(t, ID, 3'd0, 1'b1, 32'hA5A5_5A5A, 1'b1);
    wait_resp(r0, 20);
  endtask

  task automatic test_tag_wrap();
    logic [7:0] t;
    logic [31:0] d;
    int r0, t0;
    for (int i = 0; i < 256; i++) begin
      r0 = resp_cnt;
      t0 = tlp_cnt;
      d = $urandom;
      issue_cmd(1'b0, 30'(i * 4), 4'hF, 32'h0, t);
      grant(0);
      wait_tlp(t0);
      resp_q.push_back('{rdata: d, status: 3'd0, tmo: 1'b0});
      send_cpl(t, ID, 3'd0, 1'b1, d, 1'b1);
      wait_resp(r0, 20);
    end
  endtask

  task automatic test_reset_mid_send();
    logic [7:0] t;
    int r0, t0;
    issue_cmd(1'b1, 30'h0000_0040, 4'hF, 32'h1111_2222, t);
    grant(1);
    repeat (3) @(negedge clk_125);
    #1 rst = 1'b1;
    @(posedge clk_125); #1;
    tx_q.delete();
    total++;
    if ({b.cmd_ready, b.tx_req, b.tx_st, b.tx_end, b.resp_valid, b.resp_timeout} !== 6'b0 ||
        b.tx_data !== 16'h0000 || b.resp_rdata !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL midsend_reset: got strobes=%b tx_data=%h rdata=%h, required 000000 0000 ffffffff",
               {b.cmd_ready, b.tx_req, b.tx_st, b.tx_end, b.resp_valid, b.resp_timeout}, b.tx_data, b.resp_rdata);
    end
    repeat (2) @(posedge clk_125); #1;
    rst = 1'b0;
    tag_model = 8'h00;
    r0 = resp_cnt;
    repeat (10) @(posedge clk_125); #1;
    total++;
    if (resp_cnt !== r0) begin
      bad++; $display("FAIL resp_after_reset: got %0d responses, required 0", resp_cnt - r0);
    end
    resp_q.push_back('{rdata: 32'hFFFF_FFFF, status: 3'd0, tmo: 1'b0});
    issue_cmd(1'b1, 30'h0000_0044, 4'h6, 32'h3333_4444, t);
    grant(0);
    wait_resp(r0, 40);
    r0 = resp_cnt;
    t0 = tlp_cnt;
    issue_cmd(1'b0, 30'h0000_0048, 4'hF, 32'h0, t);
    grant(0);
    wait_tlp(t0);
    resp_q.push_back('{rdata: 32'h7777_8888, status: 3'd0, tmo: 1'b0});
    send_cpl(8'h00, ID, 3'd0, 1'b1, 32'h7777_8888, 1'b1);
    wait_resp(r0, 20);
  endtask

  initial begin
    b.cmd_valid = 1'b0; b.cmd_write = 1'b0; b.cmd_addr = '0; b.cmd_be = '0; b.cmd_wdata = '0;
    b.bus_num = 8'h01; b.dev_num = 5'd0; b.func_num = 3'd0;
    b.tx_ca_ph = 9'd4; b.tx_ca_pd = 13'd16; b.tx_ca_nph = 9'd4;
    b.tx_rdy = 1'b0; b.rx_st = 1'b0; b.rx_end = 1'b0; b.rx_data = 16'h0000;

    test_reset();
    test_write();
    test_read();
    test_wrong_tag();
    test_timeout();
    test_credit_wait();
    test_tag_wrap();
    test_reset_mid_send();

    repeat (5) @(posedge clk_125); #1;
    total++;
    if (tx_q.size() != 0 || resp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d tx and %0d resp pending, required 0 and 0", tx_q.size(), resp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
